// File: rtl/layer1_window_gen.sv
// Streaming 3x3 window generator for the layer-1 convolution datapath.
// Pixels arrive in raster order; two line buffers hold the previous two rows
// and the 3x3 window registers double as the column shift register. A window
// is presented once all nine of its pixels are from the current frame
// (row >= 2, col >= 2). The output stage is a single-entry register with a
// valid/ready handshake, so backpressure simply stalls pixel acceptance.
module layer1_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic [DATA_W-1:0] win9,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    // Two previous rows, indexed by column. No reset: the row/col gating
    // keeps any stale contents from ever reaching a valid window.
    logic [DATA_W-1:0] lb_top [IMG_W];
    logic [DATA_W-1:0] lb_mid [IMG_W];

    logic [DATA_W-1:0] top_rd;
    logic [DATA_W-1:0] mid_rd;
    logic              accept;
    logic              emit;
    logic              col_end;
    logic              row_end;

    // Handshake, position decode and line-buffer read of the current column.
    always_comb begin
        pix_ready = !win_valid || win_ready;
        accept    = pix_valid && pix_ready;
        col_end   = (col == COL_LAST);
        row_end   = (row == ROW_LAST);
        emit      = accept && (row >= ROW_MIN) && (col >= COL_MIN);
        top_rd    = lb_top[col];
        mid_rd    = lb_mid[col];
    end

    // Raster position counters; both wrap at the end of a frame so the next
    // pixel starts a new frame without an idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers: the middle row moves up, the new pixel becomes the middle row.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= mid_rd;
            lb_mid[col] <= pix_in;
        end
    end

    // Window shift register: shift left on every accept, new right column is
    // {top, mid, new pixel} taken from the pre-update line buffers. Accepts
    // only happen when the output slot is free or being drained, so shifting
    // never disturbs a window that is still waiting for win_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win1 <= '0;
            win2 <= '0;
            win3 <= '0;
            win4 <= '0;
            win5 <= '0;
            win6 <= '0;
            win7 <= '0;
            win8 <= '0;
            win9 <= '0;
        end else if (accept) begin
            win1 <= win2;
            win2 <= win3;
            win3 <= top_rd;
            win4 <= win5;
            win5 <= win6;
            win6 <= mid_rd;
            win7 <= win8;
            win8 <= win9;
            win9 <= pix_in;
        end
    end

    // Output valid/last: set by an emitting accept, cleared when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_last  <= row_end && col_end;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer1_window_gen.sv
// Self-checking bench for layer1_window_gen: a directed vector table, a
// signed pass-through table on a 3x3 instance, and stream scenarios checked
// against a coordinate-based image model.
module tb_layer1_window_gen;

    localparam int DW = 16;
    localparam int BOUND = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4x4 instance
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic [143:0]  win_all;
    assign win_all = {win1, win2, win3, win4, win5, win6, win7, win8, win9};

    // 3x3 instance
    logic [DW-1:0] s_pix_in;
    logic          s_pix_valid;
    logic          s_pix_ready;
    logic [DW-1:0] s_win1, s_win2, s_win3, s_win4, s_win5, s_win6, s_win7, s_win8, s_win9;
    logic          s_win_valid;
    logic          s_win_ready;
    logic          s_win_last;
    logic [143:0]  s_win_all;
    assign s_win_all = {s_win1, s_win2, s_win3, s_win4, s_win5, s_win6, s_win7, s_win8, s_win9};

    layer1_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .win1(win1), .win2(win2), .win3(win3), .win4(win4), .win5(win5),
        .win6(win6), .win7(win7), .win8(win8), .win9(win9),
        .win_valid(win_valid), .win_ready(win_ready), .win_last(win_last)
    );

    layer1_window_gen #(.DATA_W(DW), .IMG_W(3), .IMG_H(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .pix_in(s_pix_in), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .win1(s_win1), .win2(s_win2), .win3(s_win3), .win4(s_win4), .win5(s_win5),
        .win6(s_win6), .win7(s_win7), .win8(s_win8), .win9(s_win9),
        .win_valid(s_win_valid), .win_ready(s_win_ready), .win_last(s_win_last)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkw(input string name, input logic [143:0] act, input logic [143:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic checki(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [143:0] mk9(input int a, input int b, input int c,
                                         input int d, input int e, input int f,
                                         input int g, input int h, input int i);
        return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
    endfunction

    // ---------------- reference model (4x4 image, coordinate based) -------
    typedef struct {
        logic [143:0] w;
        logic         last;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] img [4][4];
    int            mr, mc;
    logic [DW-1:0] src[$];
    int            n_out, n_last;

    task automatic model_accept(input logic [DW-1:0] p);
        exp_t e;
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            e.w = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                   img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                   img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
            e.last = (mr == 3 && mc == 3);
            expq.push_back(e);
        end
        mc++;
        if (mc == 4) begin
            mc = 0;
            mr++;
            if (mr == 4) mr = 0;
        end
    endtask

    task automatic do_reset();
        pix_valid   = 1'b0;
        win_ready   = 1'b1;
        s_pix_valid = 1'b0;
        s_win_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
        expq.delete();
        src.delete();
    endtask

    // mode 0: dense, always ready; 1: stall first window 5 cycles; 2: sparse random
    task automatic run_stream(input int mode);
        int cyc  = 0;
        int hold = 0;
        bit held = 0;
        bit acc, hs;
        n_out  = 0;
        n_last = 0;
        while ((src.size() > 0 || expq.size() > 0 || win_valid) && cyc < BOUND) begin
            if (src.size() > 0 && (mode != 2 || $urandom_range(1, 0) == 1)) begin
                pix_valid = 1'b1;
                pix_in    = src[0];
            end else begin
                pix_valid = 1'b0;
                pix_in    = DW'($urandom);
            end
            if (mode == 1 && win_valid && !held) begin
                if (hold < 5) begin
                    win_ready = 1'b0;
                    hold++;
                end else begin
                    win_ready = 1'b1;
                    held = 1;
                end
            end else if (mode == 2) begin
                win_ready = 1'($urandom_range(1, 0));
            end else begin
                win_ready = 1'b1;
            end
            #1;
            checkb("pix_ready rule", pix_ready, !win_valid || win_ready);
            hs  = win_valid && win_ready;
            acc = pix_valid && pix_ready;
            if (win_valid) begin
                if (expq.size() == 0) begin
                    checkb("win_valid without emitting accept", win_valid, 1'b0);
                end else begin
                    checkw("window", win_all, expq[0].w);
                    checkb("win_last", win_last, expq[0].last);
                    if (hs) begin
                        n_out++;
                        if (win_last) n_last++;
                        void'(expq.pop_front());
                    end
                end
            end
            if (acc) begin
                model_accept(src[0]);
                void'(src.pop_front());
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checkb("stream completes within bound", cyc >= BOUND, 1'b0);
        pix_valid = 1'b0;
        win_ready = 1'b1;
    endtask

    // ---------------- directed vector table ------------------------------
    typedef struct {
        logic [DW-1:0] pix;
        logic          vld;
        logic [143:0]  win;
        logic          last;
    } vec_t;

    vec_t tab[16];
    int   sv[9] = '{-32768, -1, 0, 1, 32767, -2, 2, -3, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab[i].pix  = DW'(i);
            tab[i].vld  = 1'b0;
            tab[i].win  = '0;
            tab[i].last = 1'b0;
        end
        tab[10].vld = 1'b1; tab[10].win = mk9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        tab[11].vld = 1'b1; tab[11].win = mk9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tab[14].vld = 1'b1; tab[14].win = mk9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        tab[15].vld = 1'b1; tab[15].win = mk9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        tab[15].last = 1'b1;

        pix_in = '0; pix_valid = 1'b0; win_ready = 1'b1;
        s_pix_in = '0; s_pix_valid = 1'b0; s_win_ready = 1'b1;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkw("reset window", win_all, '0);
        checkb("reset win_valid", win_valid, 1'b0);
        checkb("reset win_last", win_last, 1'b0);
        checkb("reset pix_ready", pix_ready, 1'b1);
        checkw("reset window 3x3", s_win_all, '0);
        do_reset();

        // Scenario: window contents, table driven
        for (int i = 0; i < 16; i++) begin
            pix_valid = 1'b1;
            pix_in    = tab[i].pix;
            win_ready = 1'b1;
            #1;
            checkb("table pix_ready", pix_ready, 1'b1);
            @(posedge clk);
            #1;
            checkb($sformatf("table win_valid after pix %0d", i), win_valid, tab[i].vld);
            checkb($sformatf("table win_last after pix %0d", i), win_last, tab[i].last);
            if (tab[i].vld) checkw($sformatf("table window after pix %0d", i), win_all, tab[i].win);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        checkb("table win_valid drains", win_valid, 1'b0);
        @(negedge clk);

        // Scenario: backpressure on first window
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        run_stream(1);
        checki("backpressure window count", n_out, 4);
        checki("backpressure last count", n_last, 1);

        // Scenario: back-to-back frames
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        for (int i = 0; i < 16; i++) src.push_back(DW'(100 + i));
        run_stream(0);
        checki("back-to-back window count", n_out, 8);
        checki("back-to-back last count", n_last, 2);

        // Scenario: signed pass-through on 3x3 instance
        do_reset();
        for (int i = 0; i < 9; i++) begin
            s_pix_valid = 1'b1;
            s_pix_in    = DW'(sv[i]);
            @(posedge clk);
            #1;
            checkb($sformatf("signed win_valid after pix %0d", i), s_win_valid, i == 8);
            @(negedge clk);
        end
        s_pix_valid = 1'b0;
        checkw("signed window", s_win_all,
               mk9(sv[0], sv[1], sv[2], sv[3], sv[4], sv[5], sv[6], sv[7], sv[8]));
        checkb("signed win_last", s_win_last, 1'b1);

        // Scenario: reset mid-frame after 7 accepted pixels
        do_reset();
        for (int i = 0; i < 7; i++) src.push_back(DW'(i + 1));
        run_stream(0);
        #2;
        rst_n = 1'b0;
        #1;
        checkw("mid-frame reset window", win_all, '0);
        checkb("mid-frame reset win_valid", win_valid, 1'b0);
        checkb("mid-frame reset win_last", win_last, 1'b0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        run_stream(0);
        checki("post-reset window count", n_out, 4);
        checki("post-reset last count", n_last, 1);

        // Scenario: sparse input with random backpressure
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        run_stream(2);
        checki("sparse window count", n_out, 4);
        checki("sparse last count", n_last, 1);

        do_reset();
        for (int i = 0; i < 48; i++) src.push_back(DW'($urandom));
        run_stream(2);
        checki("random 3-frame window count", n_out, 12);
        checki("random 3-frame last count", n_last, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/layer1_window_gen.md
Name: layer1_window_gen

Overview:
- Streaming 3x3 window generator for the layer-1 convolution datapath. It sits upstream of the layer-1 multiply/tree-add stage.
- Accepts one signed 16-bit pixel per handshake, in raster order.
- Buffers two image rows internally and presents one registered 3x3 window (9 pixels) per valid output position. Valid-only convolution, no padding.
- Output handshake has backpressure; windows are never dropped.

Parameters:
- DATA_W, 16, pixel width (signed, two's complement).
- IMG_W, 28, image width in pixels (minimum 3).
- IMG_H, 28, image height in pixels (minimum 3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pix_in  input  DATA_W  signed input pixel.
- pix_valid  input  1  pix_in valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- win1..win9  output  DATA_W each  registered window, row-major: win1 = top-left, win9 = bottom-right (newest pixel).
- win_valid  output  1  window outputs valid.
- win_ready  input  1  downstream accepts the window.
- win_last  output  1  qualifies win_valid; marks the final window of a frame.

Behaviour:
- Reset: one clock, asynchronous, active-low.
  - While rst_n = 0: win1..win9 = 0, win_valid = 0, win_last = 0, col/row counters = 0, 3x3 shift registers = 0.
  - Line-buffer RAM contents are don't-care; counter gating guarantees stale data never reaches an output.
- Accept condition: accept = pix_valid & pix_ready.
  - pix_ready = !win_valid | win_ready (single-entry output pipeline register). Combinational from win_valid/win_ready only; it never depends on pix_valid.
- Per accept at counter position (row, col):
  - Line buffers: lb_top[col] <= lb_mid[col]; lb_mid[col] <= pix_in.
  - Window registers shift left one column. The new right column is {lb_top[col], lb_mid[col], pix_in}, using the pre-update line-buffer values.
  - col increments. At col = IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0. The next accepted pixel starts a new frame, with no idle cycle required.
- Window emit:
  - An accept at row >= 2 and col >= 2 loads win1..win9 with the updated 3x3 window on the next edge and sets win_valid = 1.
  - win_last = 1 iff that pixel is (IMG_H-1, IMG_W-1).
  - Latency: accept edge to win_valid high is 1 cycle.
- Output hold:
  - While win_valid & !win_ready: win1..win9, win_valid and win_last hold stable, and pix_ready = 0.
  - On win_valid & win_ready with no new emitting accept in the same cycle: win_valid <= 0, win_last <= 0; win data may hold its value.
  - Simultaneous handshake-out and emitting accept: the new window replaces the old one, win_valid stays 1. Full throughput is 1 window/cycle.
- Accepts at row < 2 or col < 2 update the buffers only; win_valid is not set by them.
- Windows per frame: (IMG_W-2)*(IMG_H-2), exactly.
- Arithmetic: pure data movement, no arithmetic on pixels; the sign bit passes unchanged.
- Reset mid-frame: all state clears immediately. The first accepted pixel after release is (0,0) of a new frame. No window emits until 2 full rows plus 3 pixels of the new frame have been accepted.
- No combinational path from pix_in to any output.

Test Plan:
- Window contents: IMG_W=4, IMG_H=4, pixels 0..15, win_ready=1 always.
  - Exactly 4 windows, emitted 1 cycle after pixels 10, 11, 14, 15 are accepted.
  - First window: win1..win9 = 0,1,2,4,5,6,8,9,10.
  - Last window: 5,6,7,9,10,11,13,14,15, with win_last=1 only on this window.
- Backpressure: same stream, win_ready=0 for 5 cycles while the first window is valid.
  - win1..win9 stay 0,1,2,4,5,6,8,9,10; win_valid stays 1; pix_ready=0 throughout.
  - After win_ready=1, the remaining windows arrive in order, none lost or duplicated.
- Back-to-back frames: two 4x4 frames, frame 2 pixels 100..115, no gap between frames.
  - Frame 2's first window is 100,101,102,104,105,106,108,109,110.
  - No frame-1 data appears in frame 2; 8 windows total; 2 win_last pulses.
- Signed pass-through: 3x3 frame of pixels -32768, -1, 0, 1, 32767, -2, 2, -3, 3.
  - One window, identical values in win1..win9 order, win_last=1.
- Reset mid-frame: assert rst_n=0 after 7 accepted pixels of a 4x4 frame.
  - All outputs 0 immediately, asynchronously.
  - After release, a fresh 0..15 frame yields exactly the 4 windows of scenario 1.
- Sparse input: pix_valid randomly low ~50% of cycles with win_ready random.
  - Window sequence is identical to scenario 1.
  - win_valid never asserts without a preceding emitting accept.
